// File: rtl/ir_pkg.sv
// Shared types and NEC timing constants for the IR transmitter.
// The repeat-code states exist only when NEC_REPEAT_EN is defined.
package ir_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
`ifdef NEC_REPEAT_EN
        , RPT_MARK
        , RPT_SPACE
        , RPT_STOP
`endif
    } ir_state_e;

    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int BIT_U        = 1;
    localparam int ONE_SPACE_U  = 3;
    localparam int RPT_SPACE_U  = 4;
    localparam int SLOT_U       = 192;
    localparam int FRAME_BITS   = 32;

    function automatic logic is_mark(input ir_state_e s);
        logic m;
        m = (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
`ifdef NEC_REPEAT_EN
        m = m || (s == RPT_MARK) || (s == RPT_STOP);
`endif
        return m;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Free-running carrier counter; restart lands it on 0 for the first cycle
// of a mark so every mark opens with the carrier high.
module ir_carrier_gen #(
    parameter int CARRIER_CYC = 1316,
    parameter int CARRIER_HI  = 439
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic gate,
    output logic ir_o
);

    localparam int CW = $clog2(CARRIER_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == CW'(CARRIER_CYC - 1))) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ir_o = gate && (cnt_q < CW'(CARRIER_HI));

endmodule

// File: rtl/nec_ir_tx.sv
// NEC IR frame transmitter: lead, 32 LSB-first data bits, stop, gap to a
// 192-unit slot. Define NEC_REPEAT_EN to send repeat codes while Start is held.
//   state      | meaning
//   IDLE       | waiting for Start
//   LEAD_MARK  | 16-unit lead burst
//   LEAD_SPACE | 8-unit lead space
//   BIT_MARK   | 1-unit burst before each data bit
//   BIT_SPACE  | 1 unit (0) or 3 units (1)
//   STOP_MARK  | closing 1-unit burst
//   GAP        | silence until slot unit 192
//   RPT_*      | repeat code: 16-unit mark, 4-unit space, 1-unit stop
module nec_ir_tx
    import ir_pkg::*;
#(
    parameter int UNIT_CYC    = 28125,
    parameter int CARRIER_CYC = 1316,
    parameter int CARRIER_HI  = 439
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic [7:0] Addr,
    input  logic [7:0] Cmd,
    output logic       Busy,
    output logic       Done,
    output logic       IR_O
);

    localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);

    ir_state_e     state_q, state_d;
    logic [UW-1:0] cyc_q, cyc_d;
    logic [4:0]    dur_q, dur_d;
    logic [7:0]    slot_q, slot_d;
    logic [5:0]    bit_q, bit_d;
    logic [31:0]   shift_q, shift_d;
    logic          unit_end, step, done, restart, mark;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        dur_d    = dur_q;
        slot_d   = slot_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done     = 1'b0;
        unit_end = (cyc_q == UNIT_LAST);
        step     = unit_end && (dur_q == '0);

        if (state_q == IDLE) begin
            cyc_d  = '0;
            slot_d = '0;
            bit_d  = '0;
            if (Start) begin
                shift_d = {~Cmd, Cmd, ~Addr, Addr};
                state_d = LEAD_MARK;
                dur_d   = 5'(LEAD_MARK_U - 1);
            end
        end else begin
            cyc_d = unit_end ? '0 : cyc_q + 1'b1;
            // dur counts remaining units of the current state down to 0
            if (unit_end) begin
                slot_d = slot_q + 1'b1;
                if (dur_q != '0) dur_d = dur_q - 1'b1;
            end
            case (state_q)
                LEAD_MARK: if (step) begin
                    state_d = LEAD_SPACE;
                    dur_d   = 5'(LEAD_SPACE_U - 1);
                end
                LEAD_SPACE: if (step) begin
                    state_d = BIT_MARK;
                    dur_d   = 5'(BIT_U - 1);
                end
                BIT_MARK: if (step) begin
                    state_d = BIT_SPACE;
                    dur_d   = shift_q[0] ? 5'(ONE_SPACE_U - 1) : 5'(BIT_U - 1);
                end
                BIT_SPACE: if (step) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    dur_d   = 5'(BIT_U - 1);
                    state_d = (bit_q == 6'(FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
                end
                STOP_MARK: if (step) state_d = GAP;
                GAP: if (unit_end && (slot_q == 8'(SLOT_U - 1))) begin
                    done   = 1'b1;
                    cyc_d  = '0;
                    slot_d = '0;
`ifdef NEC_REPEAT_EN
                    if (Start) begin
                        state_d = RPT_MARK;
                        dur_d   = 5'(LEAD_MARK_U - 1);
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
`ifdef NEC_REPEAT_EN
                RPT_MARK: if (step) begin
                    state_d = RPT_SPACE;
                    dur_d   = 5'(RPT_SPACE_U - 1);
                end
                RPT_SPACE: if (step) begin
                    state_d = RPT_STOP;
                    dur_d   = 5'(BIT_U - 1);
                end
                RPT_STOP: if (step) state_d = GAP;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            dur_q   <= '0;
            slot_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            dur_q   <= dur_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Marks are never adjacent, so a change into a mark state is a mark start.
    assign restart = is_mark(state_d) && (state_d != state_q);
    assign mark    = is_mark(state_q);
    assign Busy    = (state_q != IDLE);
    assign Done    = done;

    ir_carrier_gen #(
        .CARRIER_CYC(CARRIER_CYC),
        .CARRIER_HI (CARRIER_HI)
    ) u_carrier (
        .clk    (CLK),
        .rst    (RST),
        .restart(restart),
        .gate   (mark),
        .ir_o   (IR_O)
    );

endmodule

// File: tb/tb_nec_ir_tx.sv
// Self-checking bench for nec_ir_tx with shortened timing (unit 20, carrier 6/2).
// Expected waveforms come from a slot-level model of the NEC frame layout.
module tb_nec_ir_tx;

    localparam int U        = 20;
    localparam int CC       = 6;
    localparam int CH       = 2;
    localparam int SLOT_CYC = 192 * U;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Start;
    logic [7:0] Addr, Cmd;
    logic       Busy, Done, IR_O;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  cmd;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl[4];

    nec_ir_tx #(.UNIT_CYC(U), .CARRIER_CYC(CC), .CARRIER_HI(CH)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .Start(Start),
        .Addr (Addr),
        .Cmd  (Cmd),
        .Busy (Busy),
        .Done (Done),
        .IR_O (IR_O)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Expected IR level at slot cycle k, from the mark/space layout of a frame or repeat code.
    function automatic logic exp_ir(input logic [31:0] w, input bit rpt, input int k);
        int ms;
        int t;
        ms = -1;
        if (k < 16 * U) ms = 0;
        if (rpt) begin
            if (k >= 20 * U && k < 21 * U) ms = 20 * U;
        end else begin
            t = 24 * U;
            for (int i = 0; i < 32; i++) begin
                if (k >= t && k < t + U) ms = t;
                t += U * (w[i] ? 4 : 2);
            end
            if (k >= t && k < t + U) ms = t;
        end
        if (ms < 0) return 1'b0;
        return ((k - ms) % CC) < CH;
    endfunction

    task automatic kick(input logic [7:0] a, input logic [7:0] c, input bit hold);
        @(negedge CLK);
        Addr  = a;
        Cmd   = c;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = hold;
    endtask

    // Called at slot cycle 0 (1 time unit after the edge); returns at slot cycle 3840.
    task automatic run_slot(input string tag, input logic [31:0] w, input bit rpt,
                            input int poke_k, input logic [7:0] na, input logic [7:0] nc,
                            input bit poke_start, input bit hold);
        int          marks[$];
        int          low_run;
        int          ir_err, busy_err, done_err, first_bad;
        logic [31:0] dec;
        low_run   = 100;
        ir_err    = 0;
        busy_err  = 0;
        done_err  = 0;
        first_bad = -1;
        dec       = '0;
        for (int k = 0; k < SLOT_CYC; k++) begin
            if (IR_O !== exp_ir(w, rpt, k)) begin
                ir_err++;
                if (first_bad < 0) first_bad = k;
            end
            if (Busy !== 1'b1) busy_err++;
            if (Done !== (k == SLOT_CYC - 1)) done_err++;
            if (IR_O === 1'b1) begin
                if (low_run >= CC) marks.push_back(k);
                low_run = 0;
            end else begin
                low_run++;
            end
            if (k == poke_k) begin
                Addr = na;
                Cmd  = nc;
                if (poke_start) Start = 1'b1;
            end else if (k == poke_k + 1) begin
                Start = hold;
            end
            @(posedge CLK);
            #1;
        end
        if (marks.size() == 34) begin
            for (int i = 0; i < 32; i++) dec[i] = (marks[i + 2] - marks[i + 1]) > 3 * U;
        end
        check({tag, "_ir_wave_errs(first@", $sformatf("%0d", first_bad), ")"}, ir_err, 0);
        check({tag, "_busy_errs"}, busy_err, 0);
        check({tag, "_done_errs"}, done_err, 0);
        check({tag, "_mark_count"}, marks.size(), rpt ? 2 : 34);
        if (!rpt) check({tag, "_decoded_word"}, dec, w);
    endtask

    initial begin
        logic [7:0]  a, c, a2, c2;
        logic [31:0] w;
        int          cnt_done, cnt_busy;

        tbl[0] = '{8'h00, 8'hFF, 32'h00FFFF00};
        tbl[1] = '{8'hA5, 8'h3C, 32'hC33C5AA5};
        tbl[2] = '{8'hFF, 8'h00, 32'hFF0000FF};
        tbl[3] = '{8'h12, 8'h34, 32'hCB34ED12};

        RST   = 1'b1;
        Start = 1'b0;
        Addr  = '0;
        Cmd   = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_ir", IR_O, 0);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("idle_busy", Busy, 0);

        for (int i = 0; i < 4; i++) begin
            kick(tbl[i].addr, tbl[i].cmd, 1'b0);
            run_slot($sformatf("tbl%0d", i), tbl[i].exp_word, 1'b0, -1, 8'h00, 8'h00, 1'b0, 1'b0);
            check($sformatf("tbl%0d_end_busy", i), Busy, 0);
            check($sformatf("tbl%0d_end_ir", i), IR_O, 0);
        end

        // Start pulses and Addr/Cmd changes while busy must not disturb the frame.
        for (int r = 0; r < 3; r++) begin
            a = 8'($urandom);
            c = 8'($urandom);
            w = {~c, c, ~a, a};
            kick(a, c, 1'b0);
            run_slot($sformatf("rnd%0d", r), w, 1'b0, int'($urandom_range(1, 3800)),
                     8'($urandom), 8'($urandom), 1'b1, 1'b0);
            check($sformatf("rnd%0d_end_busy", r), Busy, 0);
            repeat (3) @(posedge CLK);
            #1;
            check($sformatf("rnd%0d_stays_idle", r), Busy, 0);
        end

        // Asynchronous reset mid-frame at slot cycle 1000 (inside a bit mark).
        a = 8'hE0;
        c = 8'h5A;
        w = {~c, c, ~a, a};
        kick(a, c, 1'b0);
        repeat (1000) begin
            @(posedge CLK);
            #1;
        end
        check("pre_rst_ir", IR_O, exp_ir(w, 1'b0, 1000));
        #1;
        RST = 1'b1;
        #1;
        check("rst_async_ir", IR_O, 0);
        check("rst_async_busy", Busy, 0);
        cnt_done = 0;
        cnt_busy = 0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (Done === 1'b1) cnt_done++;
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (200) begin
            @(posedge CLK);
            #1;
            if (Done === 1'b1) cnt_done++;
            if (Busy === 1'b1) cnt_busy++;
        end
        check("rst_no_done", cnt_done, 0);
        check("rst_stays_idle", cnt_busy, 0);
        kick(tbl[1].addr, tbl[1].cmd, 1'b0);
        run_slot("post_rst", tbl[1].exp_word, 1'b0, -1, 8'h00, 8'h00, 1'b0, 1'b0);
        check("post_rst_end_busy", Busy, 0);

        a  = 8'h3A;
        c  = 8'hC7;
        a2 = 8'h81;
        c2 = 8'h18;
`ifdef NEC_REPEAT_EN
        kick(a, c, 1'b1);
        run_slot("rpt_first", {~c, c, ~a, a}, 1'b0, -1, 8'h00, 8'h00, 1'b0, 1'b1);
        check("rpt_no_idle_gap", Busy, 1);
        run_slot("rpt_slot", 32'h0, 1'b1, 200, a2, c2, 1'b0, 1'b0);
        check("rpt_end_busy", Busy, 0);
        check("rpt_end_ir", IR_O, 0);
`else
        kick(a, c, 1'b1);
        run_slot("b2b_first", {~c, c, ~a, a}, 1'b0, 500, a2, c2, 1'b0, 1'b1);
        check("b2b_idle_cycle_busy", Busy, 0);
        check("b2b_idle_cycle_ir", IR_O, 0);
        @(posedge CLK);
        #1;
        run_slot("b2b_second", {~c2, c2, ~a2, a2}, 1'b0, 10, a2, c2, 1'b0, 1'b0);
        check("b2b_end_busy", Busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
